lcd_bus_reader: RTL and testbench
=================================

Name: lcd_bus_reader

Overview:
- Read-side engine for the HD44780-style LCD1602 parallel bus.
- The existing write path drives commands and characters into the LCD.
- This block performs RW=1 bus cycles to read the busy flag/address counter (RS=0) or DDRAM/CGRAM data (RS=1).
- Optional poll mode repeats busy-flag reads until BF clears, so the display sequencer can replace its fixed inter-command delay.

Parameters:
- T_SETUP, 4: cycles RS/RW are stable before EN rises (address setup); must be >=1.
- T_EN, 16: cycles EN is held high; must be >=1.
- T_HOLD, 4: cycles RS/RW are held after EN falls; must be >=1.
- T_GAP, 32: idle cycles between consecutive polls, RW=0 during the gap; must be >=1.
- MAX_POLLS, 255: poll-attempt limit, used only with LCD_RD_TIMEOUT_EN.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  reset, synchronous, active-high.
- iREQ  in  1  start request; sampled only in IDLE.
- iRS  in  1  register select for the request: 0 = BF/AC, 1 = data RAM.
- iPOLL  in  1  with iRS=0, repeat reads until BF=0.
- oBUSY  out  1  high in every state except IDLE.
- oDONE  out  1  one-cycle completion pulse.
- oDATA  out  8  last captured byte; holds until the next oDONE.
- oTIMEOUT  out  1  valid with oDONE; poll limit reached.
- oBUS_REQ  out  1  high SETUP..HOLD; top level releases FPGA LCD_DATA drivers (tristate).
- LCD_DATA_IN  in  8  LCD data pins as seen by the FPGA.
- LCD_RS  out  1  register select to the LCD.
- LCD_RW  out  1  read/write to the LCD; 1 = read.
- LCD_EN  out  1  enable strobe to the LCD.

Behaviour:
- Clocking: single clock iCLK. Reset is synchronous, active-high on iRST.
- Reset values: state IDLE, all counters 0, and every output = 0 (oBUSY, oDONE, oDATA=8'h00, oTIMEOUT, oBUS_REQ, LCD_RS, LCD_RW, LCD_EN).
- Reset mid-transaction: at the first iCLK edge with iRST=1, LCD_EN and LCD_RW drop to 0 and no oDONE is issued.
- Request acceptance: only in IDLE with iREQ=1. At acceptance, iRS and (iPOLL & ~iRS) are latched, then the block moves to SETUP. iREQ outside IDLE is ignored; there is no queueing.
- State IDLE: EN=0, RW=0, RS=0.
- State SETUP: RS=latched RS, RW=1, EN=0; lasts T_SETUP cycles, then EN_HIGH.
- State EN_HIGH: EN=1 for T_EN cycles. LCD_DATA_IN is registered into the capture register on the last EN_HIGH cycle.
- State HOLD: EN=0, RW=1, RS held; lasts T_HOLD cycles, then CHECK.
- State CHECK (1 cycle): RW=0, oBUS_REQ=0.
  - If poll mode and captured[7]=1: go to GAP and increment the poll counter.
  - Otherwise: go to DONE.
- State GAP: RW=0, EN=0; lasts T_GAP cycles, then SETUP.
- State DONE (1 cycle): oDONE=1, oDATA <= captured byte, then IDLE. oBUSY drops in the following cycle.
- Latency (non-poll): oDONE is high exactly T_SETUP+T_EN+T_HOLD+2 cycles after the accept cycle; 26 with default parameters.
- Latency (poll): each extra BF=1 read adds T_GAP+T_SETUP+T_EN+T_HOLD+1 cycles.
- Next request: iREQ in the same cycle as oDONE is ignored. It is accepted in the cycle after DONE at the earliest.
- iPOLL with iRS=1: treated as a single read.
- Counter width: counters are sized to the largest of T_SETUP, T_EN, T_HOLD, T_GAP. They reset to 0 on every state entry.
- Poll counter: 8 bits, saturates at 255.
- Edge alignment: LCD_EN never rises in the same cycle that RS/RW change.

Optional Feature:
- Macro: LCD_RD_TIMEOUT_EN.
- Defined: in CHECK, if poll mode and BF=1 and the poll counter has reached MAX_POLLS, go to DONE with oTIMEOUT=1. oDATA carries the last byte, with BF=1. oTIMEOUT clears on the next accept.
- Undefined: polling continues indefinitely and oTIMEOUT is tied to 0.

Test Plan:
- Reset: hold iRST=1 for 3 cycles mid-EN_HIGH -> next edge LCD_EN=0, LCD_RW=0, oBUSY=0, oDATA=8'h00, no oDONE.
- Single BF/AC read: iRS=0, iPOLL=0, LCD_DATA_IN=8'h85 -> LCD_EN high exactly 16 cycles, RW=1 for 24 cycles, oDONE 26 cycles after accept, oDATA=8'h85.
- Data-RAM read: iRS=1, iPOLL=1, LCD_DATA_IN=8'h41 -> LCD_RS=1 during SETUP..HOLD, a single EN pulse (poll ignored), oDATA=8'h41.
- Poll: iRS=0, iPOLL=1, pins 8'h80 for the first 3 reads and then 8'h05 -> exactly 4 EN pulses, each separated by 32+ RW=0 cycles; oDONE with oDATA=8'h05, oTIMEOUT=0.
- Timeout (macro defined, MAX_POLLS=3): pins stuck at 8'hFF -> 4 EN pulses, then oDONE with oTIMEOUT=1, oDATA=8'hFF.
- Request during busy: pulse iREQ in EN_HIGH and again in the oDONE cycle -> both ignored, no second transaction; a request one cycle after oDONE is accepted.

Source files
------------

// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader
// ----------------------------------------------------------------------------------------------
// Read-side engine for an HD44780-style (LCD1602) parallel bus. It runs RW=1 bus cycles to fetch
// either the busy flag / address counter (RS=0) or DDRAM/CGRAM data (RS=1). In poll mode
// (iPOLL with iRS=0) it repeats busy-flag reads, separated by an RW=0 gap, until BF (bit 7)
// reads back as 0. The display sequencer can then wait on oDONE instead of a fixed delay.
//
// Bus cycle shape per read: SETUP (RS/RW stable, EN low) -> EN_HIGH -> HOLD (RS/RW still stable,
// EN low) -> CHECK. Because RS/RW settle in SETUP, which lasts at least one cycle, EN never rises
// in the same cycle that RS/RW change.
//
// Parameters
//   T_SETUP    cycles RS/RW are stable before EN rises (>= 1)
//   T_EN       cycles EN is held high (>= 1)
//   T_HOLD     cycles RS/RW are held after EN falls (>= 1)
//   T_GAP      idle cycles (RW=0) between consecutive polls (>= 1)
//   MAX_POLLS  poll-attempt limit; only acts when LCD_RD_TIMEOUT_EN is defined
//
// Optional feature (macro LCD_RD_TIMEOUT_EN)
//   Defined:   polling gives up once the poll counter reaches MAX_POLLS while BF is still 1;
//              the transaction completes with oTIMEOUT=1 and oDATA holding the last byte.
//   Undefined: polling continues until BF clears; oTIMEOUT is tied to 0.
//
// Ports
//   iCLK         system clock
//   iRST         synchronous, active-high reset
//   iREQ         start request, sampled only while idle
//   iRS          register select for the request: 0 = BF/AC, 1 = data RAM
//   iPOLL        with iRS=0, repeat reads until BF=0
//   oBUSY        high in every state except idle
//   oDONE        one-cycle completion pulse
//   oDATA        last captured byte, valid with oDONE and held until the next oDONE
//   oTIMEOUT     valid with oDONE: poll limit reached (cleared on the next accept)
//   oBUS_REQ     high while the LCD drives the data pins; top level releases its drivers
//   LCD_DATA_IN  LCD data pins as seen by the FPGA
//   LCD_RS       register select to the LCD
//   LCD_RW       read/write to the LCD, 1 = read
//   LCD_EN       enable strobe to the LCD
// ----------------------------------------------------------------------------------------------

module lcd_bus_reader #(
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_EN      = 16,
  parameter int unsigned T_HOLD    = 4,
  parameter int unsigned T_GAP     = 32,
  parameter int unsigned MAX_POLLS = 255
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iREQ,
  input  logic       iRS,
  input  logic       iPOLL,
  output logic       oBUSY,
  output logic       oDONE,
  output logic [7:0] oDATA,
  output logic       oTIMEOUT,
  output logic       oBUS_REQ,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  // ---------------------------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------------------------

  localparam int unsigned MaxSetupEn = (T_SETUP > T_EN) ? T_SETUP : T_EN;
  localparam int unsigned MaxHoldGap = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int unsigned CntMax     = (MaxSetupEn > MaxHoldGap) ? MaxSetupEn : MaxHoldGap;
  // The counter only needs to reach CntMax-1 before the state changes.
  localparam int unsigned CntW       = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] SetupLast = CntW'(T_SETUP - 1);
  localparam logic [CntW-1:0] EnLast    = CntW'(T_EN - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(T_HOLD - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(T_GAP - 1);

  // The poll counter is 8 bits, so a limit above 255 behaves as 255.
  localparam logic [7:0] PollLimit = (MAX_POLLS > 255) ? 8'hFF : 8'(MAX_POLLS);

`ifdef LCD_RD_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------------------------

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StEnHigh,
    StHold,
    StCheck,
    StGap,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rs_q;
  logic              poll_q;
  logic [7:0]        cap_q;
  logic [7:0]        data_q;
  logic [7:0]        poll_cnt_q;

  logic              accept;
  logic              timed_state;
  logic              timer_done;
  logic              limit_hit;
  logic              check_timeout;

  assign accept = (state_q == StIdle) && iREQ;

  // Only reachable in poll mode with BF still set, so it is exactly the timeout condition.
  assign limit_hit     = TimeoutEn && (poll_cnt_q >= PollLimit);
  assign check_timeout = poll_q && cap_q[7] && limit_hit;

  // ---------------------------------------------------------------------------------------------
  // Per-state timer
  // ---------------------------------------------------------------------------------------------

  always_comb begin
    timed_state = 1'b0;
    timer_done  = 1'b0;
    case (state_q)
      StSetup: begin
        timed_state = 1'b1;
        timer_done  = (cnt_q == SetupLast);
      end
      StEnHigh: begin
        timed_state = 1'b1;
        timer_done  = (cnt_q == EnLast);
      end
      StHold: begin
        timed_state = 1'b1;
        timer_done  = (cnt_q == HoldLast);
      end
      StGap: begin
        timed_state = 1'b1;
        timer_done  = (cnt_q == GapLast);
      end
      default: begin
        timed_state = 1'b0;
        timer_done  = 1'b0;
      end
    endcase
  end

  // Restart from zero on every state entry; untimed states keep it parked at zero.
  always_comb begin
    if ((state_d != state_q) || !timed_state) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------------

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------------------------

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (iREQ) state_d = StSetup;
      end
      StSetup: begin
        if (timer_done) state_d = StEnHigh;
      end
      StEnHigh: begin
        if (timer_done) state_d = StHold;
      end
      StHold: begin
        if (timer_done) state_d = StCheck;
      end
      StCheck: begin
        if (poll_q && cap_q[7] && !limit_hit) begin
          state_d = StGap;
        end else begin
          state_d = StDone;
        end
      end
      StGap: begin
        if (timer_done) state_d = StSetup;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------------------------

  always_comb begin
    oBUSY    = 1'b1;
    oDONE    = 1'b0;
    oBUS_REQ = 1'b0;
    LCD_RS   = 1'b0;
    LCD_RW   = 1'b0;
    LCD_EN   = 1'b0;
    case (state_q)
      StIdle: begin
        oBUSY = 1'b0;
      end
      StSetup, StHold: begin
        oBUS_REQ = 1'b1;
        LCD_RS   = rs_q;
        LCD_RW   = 1'b1;
      end
      StEnHigh: begin
        oBUS_REQ = 1'b1;
        LCD_RS   = rs_q;
        LCD_RW   = 1'b1;
        LCD_EN   = 1'b1;
      end
      StDone: begin
        oDONE = 1'b1;
      end
      default: begin
        oBUSY = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Request latch, capture, result and poll counter
  // ---------------------------------------------------------------------------------------------

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
      cap_q      <= 8'h00;
      data_q     <= 8'h00;
      poll_cnt_q <= 8'h00;
    end else begin
      if (accept) begin
        rs_q       <= iRS;
        // Polling only makes sense on the busy flag; a data-RAM poll is a single read.
        poll_q     <= iPOLL & ~iRS;
        poll_cnt_q <= 8'h00;
      end else if ((state_q == StCheck) && (state_d == StGap) && (poll_cnt_q != 8'hFF)) begin
        poll_cnt_q <= poll_cnt_q + 8'd1;
      end

      // Sample on the last EN-high cycle, when the LCD output has had the full strobe to settle.
      if ((state_q == StEnHigh) && timer_done) begin
        cap_q <= LCD_DATA_IN;
      end

      // Loaded on entry to DONE so the byte is already valid during the oDONE pulse.
      if ((state_q == StCheck) && (state_d == StDone)) begin
        data_q <= cap_q;
      end
    end
  end

  assign oDATA = data_q;

  // ---------------------------------------------------------------------------------------------
  // Timeout flag
  // ---------------------------------------------------------------------------------------------

`ifdef LCD_RD_TIMEOUT_EN
  logic timeout_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      timeout_q <= 1'b0;
    end else if (accept) begin
      timeout_q <= 1'b0;
    end else if ((state_q == StCheck) && (state_d == StDone)) begin
      timeout_q <= check_timeout;
    end
  end

  assign oTIMEOUT = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = check_timeout;
  assign oTIMEOUT       = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Self-checking bench for lcd_bus_reader. A driver issues read requests and pushes the expected
// outcome (byte, timeout flag, completion cycle, EN pulse count) computed from the read script
// into a scoreboard queue. A monitor on the falling edge plays the LCD (drives LCD_DATA_IN while
// EN is high), watches bus timing and pops/compares on every oDONE.

module tb_lcd_bus_reader;

  localparam int TS      = 4;
  localparam int TE      = 16;
  localparam int TH      = 4;
  localparam int TG      = 32;
  localparam int ReadLen = TS + TE + TH;

`ifdef LCD_RD_TIMEOUT_EN
  localparam int unsigned TbMaxPolls = 3;
  localparam bit          TimeoutEn  = 1'b1;
  localparam int          MaxBf      = 5;
`else
  localparam int unsigned TbMaxPolls = 255;
  localparam bit          TimeoutEn  = 1'b0;
  localparam int          MaxBf      = 4;
`endif

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iREQ = 1'b0;
  logic       iRS = 1'b0;
  logic       iPOLL = 1'b0;
  logic       oBUSY, oDONE, oTIMEOUT, oBUS_REQ;
  logic [7:0] oDATA;
  logic [7:0] LCD_DATA_IN = 8'h00;
  logic       LCD_RS, LCD_RW, LCD_EN;

  lcd_bus_reader #(
    .T_SETUP  (TS),
    .T_EN     (TE),
    .T_HOLD   (TH),
    .T_GAP    (TG),
    .MAX_POLLS(TbMaxPolls)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iREQ       (iREQ),
    .iRS        (iRS),
    .iPOLL      (iPOLL),
    .oBUSY      (oBUSY),
    .oDONE      (oDONE),
    .oDATA      (oDATA),
    .oTIMEOUT   (oTIMEOUT),
    .oBUS_REQ   (oBUS_REQ),
    .LCD_DATA_IN(LCD_DATA_IN),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_EN     (LCD_EN)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [7:0] data;
    logic       tmo;
    logic       rs;
    int         done_cyc;
    int         pulses;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] script[$];   // bytes the LCD returns on successive reads of the current request
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         idle_bad = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
  endtask

  // Reference model: how many reads the request takes, what it returns and when it completes.
  function automatic exp_t model(input logic rs, input logic poll, input int acc);
    exp_t e;
    int   n;
    bit   pmode;
    pmode = poll && !rs;
    n = 1;
    if (pmode) begin
      n = script.size();
      for (int i = script.size() - 1; i >= 0; i--) begin
        if (!script[i][7]) n = i + 1;
      end
    end
    e.tmo = 1'b0;
    if (TimeoutEn && pmode && (n > int'(TbMaxPolls) + 1)) begin
      n     = int'(TbMaxPolls) + 1;
      e.tmo = 1'b1;
    end
    e.data     = script[n-1];
    e.rs       = rs;
    e.pulses   = n;
    e.done_cyc = acc + ReadLen + 2 + (n - 1) * (TG + ReadLen + 1);
    return e;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Monitor / LCD model
  // ---------------------------------------------------------------------------------------------

  initial begin
    int   pulses = 0;
    int   rw_cyc = 0;
    int   viol = 0;
    int   en_run = 0;
    int   low_run = 0;
    int   idx;
    logic prev_en = 1'b0;
    logic prev_rw = 1'b0;
    logic prev_rs = 1'b0;
    exp_t e;
    forever begin
      @(negedge iCLK);
      if (iRST) begin
        pulses = 0; rw_cyc = 0; viol = 0; en_run = 0; low_run = 0;
        LCD_DATA_IN = 8'($urandom);
      end else begin
        if (LCD_EN && !prev_en && ((LCD_RS !== prev_rs) || (LCD_RW !== prev_rw))) viol++;
        if (LCD_EN && !LCD_RW) viol++;
        if (oBUS_REQ !== LCD_RW) viol++;
        if (LCD_RW && (sb_q.size() > 0) && (LCD_RS !== sb_q[0].rs)) viol++;
        if (LCD_EN) begin
          en_run++;
        end else if (prev_en) begin
          if (en_run != TE) viol++;
          pulses++;
          en_run = 0;
        end
        if (!LCD_RW) begin
          low_run++;
        end else begin
          if (!prev_rw && (pulses > 0) && (low_run < TG)) viol++;
          low_run = 0;
          rw_cyc++;
        end
        // The LCD drives its output only while EN is high; otherwise the pins float (junk).
        if (LCD_EN && (script.size() > 0)) begin
          idx = (pulses < script.size()) ? pulses : script.size() - 1;
          LCD_DATA_IN = script[idx];
        end else begin
          LCD_DATA_IN = 8'($urandom);
        end
        if ((sb_q.size() == 0) && oBUSY) idle_bad++;
        if (oDONE) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'(oDONE), 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("done_data", 32'(oDATA), 32'(e.data));
            chk("done_timeout", 32'(oTIMEOUT), 32'(e.tmo));
            chk("done_cycle", cyc, e.done_cyc);
            chk("en_pulses", pulses, e.pulses);
            chk("rw_cycles", rw_cyc, e.pulses * ReadLen);
            chk("bus_timing_violations", viol, 0);
          end
          pulses = 0; rw_cyc = 0; viol = 0;
        end
      end
      prev_en = LCD_EN;
      prev_rw = LCD_RW;
      prev_rs = LCD_RS;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Driver (acts 2 time units after the rising edge)
  // ---------------------------------------------------------------------------------------------

  task automatic issue(input logic rs, input logic poll);
    sb_q.push_back(model(rs, poll, cyc));
    iRS   = rs;
    iPOLL = poll;
    iREQ  = 1'b1;
    @(posedge iCLK); #2;
    iREQ  = 1'b0;
    iRS   = 1'($urandom);
    iPOLL = 1'($urandom);
  endtask

  task automatic recover();
    iRST = 1'b1;
    iREQ = 1'b0;
    sb_q.delete();
    repeat (3) @(posedge iCLK);
    #2;
    iRST = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge iCLK); #2;
      if (!oBUSY && (sb_q.size() == 0)) return;
    end
    fail_now("wait_idle");
    recover();
  endtask

  task automatic wait_en(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge iCLK); #2;
      if (LCD_EN) ok = 1'b1;
    end
    if (!ok) fail_now("wait_en");
  endtask

  initial begin
    bit   ok;
    bit   got;
    logic rs, poll;
    int   nbf;

    // Reset values.
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_busy", 32'(oBUSY), 32'd0);
    chk("rst_done", 32'(oDONE), 32'd0);
    chk("rst_data", 32'(oDATA), 32'd0);
    chk("rst_timeout", 32'(oTIMEOUT), 32'd0);
    chk("rst_bus_req", 32'(oBUS_REQ), 32'd0);
    chk("rst_lcd_rs", 32'(LCD_RS), 32'd0);
    chk("rst_lcd_rw", 32'(LCD_RW), 32'd0);
    chk("rst_lcd_en", 32'(LCD_EN), 32'd0);
    #1;
    iRST = 1'b0;

    // Reset in the middle of EN_HIGH: bus released at the first reset edge, no completion.
    script.delete();
    script.push_back(8'h3C);
    issue(1'b1, 1'b0);
    wait_en(100, ok);
    repeat (3) begin @(posedge iCLK); #2; end
    iRST = 1'b1;
    sb_q.delete();
    @(posedge iCLK); #1;
    chk("midrst_lcd_en", 32'(LCD_EN), 32'd0);
    chk("midrst_lcd_rw", 32'(LCD_RW), 32'd0);
    chk("midrst_busy", 32'(oBUSY), 32'd0);
    chk("midrst_data", 32'(oDATA), 32'd0);
    chk("midrst_done", 32'(oDONE), 32'd0);
    #1;
    repeat (2) begin @(posedge iCLK); #2; end
    iRST = 1'b0;
    repeat (2) begin @(posedge iCLK); #2; end

    // Single BF/AC read.
    script.delete();
    script.push_back(8'h85);
    issue(1'b0, 1'b0);
    wait_idle(500);

    // Data-RAM read with iPOLL set: still one read.
    script.delete();
    script.push_back(8'h41);
    issue(1'b1, 1'b1);
    wait_idle(500);

    // Poll until BF clears on the fourth read.
    script.delete();
    repeat (3) script.push_back(8'h80);
    script.push_back(8'h05);
    issue(1'b0, 1'b1);
    wait_idle(2000);

    // Busy flag stuck: only terminates when the timeout is built in.
    if (TimeoutEn) begin
      script.delete();
      repeat (8) script.push_back(8'hFF);
      issue(1'b0, 1'b1);
      wait_idle(2000);
    end

    // Requests during EN_HIGH and in the oDONE cycle are ignored; the next cycle is accepted.
    script.delete();
    script.push_back(8'h12);
    issue(1'b0, 1'b0);
    wait_en(100, ok);
    iREQ = 1'b1; iRS = 1'b1; iPOLL = 1'b0;
    @(posedge iCLK); #2;
    iREQ = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge iCLK); #2;
      if (oDONE) got = 1'b1;
    end
    if (!got) begin
      fail_now("wait_done");
      recover();
    end else begin
      script.delete();
      script.push_back(8'h77);
      sb_q.push_back(model(1'b1, 1'b0, cyc + 1));
      iRS = 1'b1; iPOLL = 1'b0; iREQ = 1'b1;
      @(posedge iCLK); #2;
      @(posedge iCLK); #2;
      iREQ = 1'b0;
    end
    wait_idle(500);

    // Randomized requests.
    for (int t = 0; t < 25; t++) begin
      rs   = 1'($urandom);
      poll = 1'($urandom);
      script.delete();
      if (poll && !rs) begin
        nbf = int'($urandom_range(0, MaxBf));
        repeat (nbf) script.push_back(8'h80 | 8'($urandom));
        script.push_back(8'($urandom) & 8'h7F);
      end else begin
        script.push_back(8'($urandom));
      end
      repeat ($urandom_range(0, 3)) begin @(posedge iCLK); #2; end
      issue(rs, poll);
      wait_idle(3000);
    end

    repeat (5) @(posedge iCLK);
    chk("busy_while_idle", idle_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
